// File: rtl/lvds_word_aligner_if.sv
// Deserialiser-side bundle for the LVDS word aligner: the received word and
// control inputs in one direction, the alignment status and bitslip in the other.
interface lvds_word_aligner_if #(
  parameter int DATA_W   = 10,
  parameter int MAX_SLIP = DATA_W
);
  localparam int SLIP_CNT_W = $clog2(MAX_SLIP + 1);

  logic [DATA_W-1:0]     rx_data;
  logic                  en;
  logic                  lock_mon;
  logic                  bitslip;
  logic                  align_done;
  logic                  align_fail;
  logic                  lock_lost;
  logic [SLIP_CNT_W-1:0] slip_cnt;

  modport master (
    output rx_data, en, lock_mon,
    input  bitslip, align_done, align_fail, lock_lost, slip_cnt
  );

  modport slave (
    input  rx_data, en, lock_mon,
    output bitslip, align_done, align_fail, lock_lost, slip_cnt
  );
endinterface

// File: rtl/lvds_word_aligner.sv
// Word aligner: pulses bitslip until CHECK_N consecutive commas are seen, then
// optionally monitors training traffic and re-aligns after LOSS_N bad words.
module lvds_word_aligner #(
  parameter int                DATA_W    = 10,
  parameter logic [DATA_W-1:0] COMMA1    = 10'b0101111100,
  parameter logic [DATA_W-1:0] COMMA2    = 10'b1010000011,
  parameter int                SLIP_WAIT = 10,
  parameter int                CHECK_N   = 3,
  parameter int                MAX_SLIP  = DATA_W,
  parameter int                LOSS_N    = 4
) (
  input logic                 rx_clk,
  input logic                 rst_n,
  lvds_word_aligner_if.slave  bus
);
  localparam int SW = $clog2(MAX_SLIP + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam int CW = $clog2(CHECK_N + 1);
  localparam int LW = $clog2(LOSS_N + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_SLIP   = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0] good_cnt_q, good_cnt_d;
  logic [LW-1:0] loss_cnt_q, loss_cnt_d;
  logic [SW-1:0] slip_cnt_q, slip_cnt_d;
  logic          bitslip_q, bitslip_d;
  logic          align_done_q, align_done_d;
  logic          align_fail_q, align_fail_d;
  logic          lock_lost_q, lock_lost_d;
  logic          comma;

  assign comma = (bus.rx_data == COMMA1) || (bus.rx_data == COMMA2);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    good_cnt_d   = good_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    bitslip_d    = 1'b0;
    align_done_d = align_done_q;
    align_fail_d = align_fail_q;
    lock_lost_d  = 1'b0;

    if (!bus.en) begin
      // Abort beats every other event, including a pending lock or loss.
      state_d      = S_IDLE;
      wait_cnt_d   = '0;
      good_cnt_d   = '0;
      loss_cnt_d   = '0;
      slip_cnt_d   = '0;
      align_done_d = 1'b0;
      align_fail_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
        S_WAIT: begin
          if (wait_cnt_q == WW'(SLIP_WAIT - 1)) begin
            state_d    = S_CHECK;
            good_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
        end
        S_CHECK: begin
          if (comma) begin
            if (good_cnt_q == CW'(CHECK_N - 1)) begin
              state_d      = S_LOCKED;
              align_done_d = 1'b1;
              loss_cnt_d   = '0;
            end else begin
              good_cnt_d = good_cnt_q + CW'(1);
            end
          end else if (slip_cnt_q < SW'(MAX_SLIP)) begin
            state_d    = S_SLIP;
            bitslip_d  = 1'b1;
            slip_cnt_d = slip_cnt_q + SW'(1);
          end else begin
            state_d      = S_FAIL;
            align_fail_d = 1'b1;
          end
        end
        S_SLIP: begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
        S_LOCKED: begin
          if (!bus.lock_mon || comma) begin
            loss_cnt_d = '0;
          end else if (loss_cnt_q == LW'(LOSS_N - 1)) begin
            // Re-check starts from the current slip position, no slip first.
            state_d      = S_WAIT;
            wait_cnt_d   = '0;
            loss_cnt_d   = '0;
            slip_cnt_d   = '0;
            align_done_d = 1'b0;
            lock_lost_d  = 1'b1;
          end else begin
            loss_cnt_d = loss_cnt_q + LW'(1);
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      good_cnt_q   <= '0;
      loss_cnt_q   <= '0;
      slip_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
      align_done_q <= 1'b0;
      align_fail_q <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      good_cnt_q   <= good_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      bitslip_q    <= bitslip_d;
      align_done_q <= align_done_d;
      align_fail_q <= align_fail_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign bus.bitslip    = bitslip_q;
  assign bus.align_done = align_done_q;
  assign bus.align_fail = align_fail_q;
  assign bus.lock_lost  = lock_lost_q;
  assign bus.slip_cnt   = slip_cnt_q;
endmodule
